// File: rtl/alu_issue_ctrl.sv
// Two-stage issue/result front end for a 32-bit combinational ALU: S1 holds decoded operands, S2 the captured result.
// Build option: define ALU_ILLEGAL_TRAP_EN to carry illegal instructions down the pipe flagged on resIllegal.
module alu_issue_ctrl #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            instValid,
    output logic            instReady,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rs1Data,
    input  logic [XLEN-1:0] rs2Data,
    output logic [XLEN-1:0] opA,
    output logic [XLEN-1:0] opB,
    output logic [3:0]      aluOutSel,
    input  logic [XLEN-1:0] aluOut,
    output logic            resValid,
    input  logic            resReady,
    output logic [XLEN-1:0] resData,
    output logic [RD_W-1:0] resRd,
    output logic            resIllegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_SUB  = 4'b0001;
    localparam logic [3:0] SEL_XOR  = 4'b0010;
    localparam logic [3:0] SEL_OR   = 4'b0011;
    localparam logic [3:0] SEL_AND  = 4'b0100;
    localparam logic [3:0] SEL_SLT  = 4'b0101;
    localparam logic [3:0] SEL_SLTU = 4'b0110;
    localparam logic [3:0] SEL_SLL  = 4'b0111;
    localparam logic [3:0] SEL_SRL  = 4'b1000;
    localparam logic [3:0] SEL_SRA  = 4'b1001;

    // Both ports use valid/ready: a beat transfers on the rising edge where valid and ready
    // are both high; a producer holding valid keeps its payload stable until that edge.

    logic            s1_valid_q, s1_valid_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [3:0]      alu_sel_q, alu_sel_d;
    logic [RD_W-1:0] s1_rd_q, s1_rd_d;
    logic            s1_ill_q, s1_ill_d;

    logic            res_valid_q, res_valid_d;
    logic [XLEN-1:0] res_data_q, res_data_d;
    logic [RD_W-1:0] res_rd_q, res_rd_d;
    logic            res_ill_q, res_ill_d;

    logic            s2_adv;
    logic            in_fire;
    logic            s2_load;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [3:0]      dec_sel;
    logic            dec_ill;
    logic            dec_shift;

    // The rs1 index field is resolved by the register file upstream.
    logic            unused_rs1_idx;
    assign unused_rs1_idx = ^inst[19:15];

    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign funct7   = inst[31:25];
    assign imm_sext = {{(XLEN-12){inst[31]}}, inst[31:20]};

    assign s2_adv    = !res_valid_q || resReady;
    assign instReady = !s1_valid_q || s2_adv;
    assign in_fire   = instValid && instReady;
    assign s2_load   = s1_valid_q && s2_adv;

    always_comb begin
        dec_a     = rs1Data;
        dec_b     = rs2Data;
        dec_sel   = SEL_ADD;
        dec_ill   = 1'b0;
        dec_shift = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (funct3)
                    3'b000:  dec_sel = funct7[5] ? SEL_SUB : SEL_ADD;
                    3'b001:  dec_sel = SEL_SLL;
                    3'b010:  dec_sel = SEL_SLT;
                    3'b011:  dec_sel = SEL_SLTU;
                    3'b100:  dec_sel = SEL_XOR;
                    3'b101:  dec_sel = funct7[5] ? SEL_SRA : SEL_SRL;
                    3'b110:  dec_sel = SEL_OR;
                    default: dec_sel = SEL_AND;
                endcase
                dec_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
                if (!((funct7 == F7_BASE) ||
                      ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))))) begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_b = imm_sext;
                case (funct3)
                    3'b000: dec_sel = SEL_ADD;
                    3'b001: begin
                        dec_sel = SEL_SLL;
                        dec_ill = (funct7 != F7_BASE);
                    end
                    3'b010: dec_sel = SEL_SLT;
                    3'b011: dec_sel = SEL_SLTU;
                    3'b100: dec_sel = SEL_XOR;
                    3'b101: begin
                        dec_sel = inst[30] ? SEL_SRA : SEL_SRL;
                        dec_ill = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
                    end
                    3'b110:  dec_sel = SEL_OR;
                    default: dec_sel = SEL_AND;
                endcase
                dec_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
            end
            default: dec_ill = 1'b1;
        endcase

        // Shift counts are confined to 0..31 whatever the upper operand bits hold.
        if (dec_shift) begin
            dec_b = {{(XLEN-5){1'b0}}, dec_b[4:0]};
        end

        if (dec_ill) begin
            dec_sel = SEL_ADD;
            dec_b   = '0;
`ifdef ALU_ILLEGAL_TRAP_EN
            dec_a   = '0;
`else
            dec_a   = rs1Data;
`endif
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        alu_sel_d  = alu_sel_q;
        s1_rd_d    = s1_rd_q;
        s1_ill_d   = s1_ill_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            op_a_d     = dec_a;
            op_b_d     = dec_b;
            alu_sel_d  = dec_sel;
            s1_rd_d    = inst[7 +: RD_W];
`ifdef ALU_ILLEGAL_TRAP_EN
            s1_ill_d   = dec_ill;
`else
            s1_ill_d   = 1'b0;
`endif
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        res_valid_d = s2_adv ? s1_valid_q : res_valid_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        res_ill_d   = res_ill_q;
        if (s2_load) begin
            res_data_d = aluOut;
            res_rd_d   = s1_rd_q;
            res_ill_d  = s1_ill_q;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            s1_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            alu_sel_q   <= SEL_ADD;
            s1_rd_q     <= '0;
            s1_ill_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_ill_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            alu_sel_q   <= alu_sel_d;
            s1_rd_q     <= s1_rd_d;
            s1_ill_q    <= s1_ill_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_ill_q   <= res_ill_d;
        end
    end

    assign opA        = op_a_q;
    assign opB        = op_b_q;
    assign aluOutSel  = alu_sel_q;
    assign resValid   = res_valid_q;
    assign resData    = res_data_q;
    assign resRd      = res_rd_q;
    assign resIllegal = res_ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed cases, then randomized traffic scored against an instruction-level model.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rstN;
    logic        instValid;
    logic        instReady;
    logic [31:0] inst;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [3:0]  aluOutSel;
    logic [31:0] aluOut;
    logic        resValid;
    logic        resReady;
    logic [31:0] resData;
    logic [4:0]  resRd;
    logic        resIllegal;

    int checks = 0;
    int errors = 0;

    // {illegal, rd, data}
    logic [37:0] exp_q[$];

    logic        hold_valid = 1'b0;
    logic [31:0] hold_data;
    logic [4:0]  hold_rd;
    logic        hold_ill;

    alu_issue_ctrl dut (
        .clk        (clk),
        .rstN       (rstN),
        .instValid  (instValid),
        .instReady  (instReady),
        .inst       (inst),
        .rs1Data    (rs1Data),
        .rs2Data    (rs2Data),
        .opA        (opA),
        .opB        (opB),
        .aluOutSel  (aluOutSel),
        .aluOut     (aluOut),
        .resValid   (resValid),
        .resReady   (resReady),
        .resData    (resData),
        .resRd      (resRd),
        .resIllegal (resIllegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU that sits between S1 and S2.
    always_comb begin
        case (aluOutSel)
            4'd0:    aluOut = opA + opB;
            4'd1:    aluOut = opA - opB;
            4'd2:    aluOut = opA ^ opB;
            4'd3:    aluOut = opA | opB;
            4'd4:    aluOut = opA & opB;
            4'd5:    aluOut = {31'b0, $signed(opA) < $signed(opB)};
            4'd6:    aluOut = {31'b0, opA < opB};
            4'd7:    aluOut = opA << opB;
            4'd8:    aluOut = opA >> opB;
            4'd9:    aluOut = $signed(opA) >>> opB;
            default: aluOut = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of one RV32I OP/OP-IMM instruction.
    function automatic logic [37:0] ref_model(input logic [31:0] i, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [4:0]  sh;
        logic        ill;
        logic [31:0] r;
        op  = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        imm = {{20{i[31]}}, i[31:20]};
        sh  = i[24:20];
        ill = 1'b0;
        r   = 32'h0;
        if (op == 7'h33) begin
            if (f7 == 7'h00) begin
                case (f3)
                    3'd0: r = a + b;
                    3'd1: r = a << b[4:0];
                    3'd2: r = {31'b0, $signed(a) < $signed(b)};
                    3'd3: r = {31'b0, a < b};
                    3'd4: r = a ^ b;
                    3'd5: r = a >> b[4:0];
                    3'd6: r = a | b;
                    default: r = a & b;
                endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                r = a - b;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                r = $signed(a) >>> b[4:0];
            end else begin
                ill = 1'b1;
            end
        end else if (op == 7'h13) begin
            case (f3)
                3'd0: r = a + imm;
                3'd1: if (f7 == 7'h00) r = a << sh; else ill = 1'b1;
                3'd2: r = {31'b0, $signed(a) < $signed(imm)};
                3'd3: r = {31'b0, a < imm};
                3'd4: r = a ^ imm;
                3'd5: begin
                    if (f7 == 7'h00) r = a >> sh;
                    else if (f7 == 7'h20) r = $signed(a) >>> sh;
                    else ill = 1'b1;
                end
                3'd6: r = a | imm;
                default: r = a & imm;
            endcase
        end else begin
            ill = 1'b1;
        end
        if (ill) begin
`ifdef ALU_ILLEGAL_TRAP_EN
            r = 32'h0;
`else
            r   = a;
            ill = 1'b0;
`endif
        end
        return {ill, i[11:7], r};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [4:0] rd;
        int         pick;
        pick = $urandom_range(0, 9);
        if (pick < 4)      op = 7'h33;
        else if (pick < 8) op = 7'h13;
        else               op = 7'($urandom_range(0, 127));
        pick = $urandom_range(0, 3);
        if (pick < 2)       f7 = 7'h00;
        else if (pick == 2) f7 = 7'h20;
        else                f7 = 7'($urandom_range(0, 127));
        f3  = 3'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(0, 31));
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    // Present one instruction and hold it until it is accepted (bounded).
    task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        int waited;
        @(negedge clk);
        instValid = 1'b1;
        inst      = i;
        rs1Data   = a;
        rs2Data   = b;
        #1;
        waited = 0;
        while (!instReady && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("send_ready", {31'b0, instReady}, 32'd1);
        if (instReady) exp_q.push_back(ref_model(i, a, b));
        @(posedge clk);
        #1;
        instValid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            #3;
            budget++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Result scoreboard and stall-stability monitor.
    always @(negedge clk) begin
        logic [37:0] e;
        #2;
        if (!rstN) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("stall_valid", {31'b0, resValid}, 32'd1);
                check("stall_data", resData, hold_data);
                check("stall_rd", {27'b0, resRd}, {27'b0, hold_rd});
                check("stall_ill", {31'b0, resIllegal}, {31'b0, hold_ill});
            end
            if (resValid && resReady) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {31'b0, resValid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", resData, e[31:0]);
                    check("res_rd", {27'b0, resRd}, {27'b0, e[36:32]});
                    check("res_ill", {31'b0, resIllegal}, {31'b0, e[37]});
                end
            end
            hold_valid = resValid && !resReady;
            hold_data  = resData;
            hold_rd    = resRd;
            hold_ill   = resIllegal;
        end
    end

    initial begin
        rstN      = 1'b0;
        instValid = 1'b0;
        inst      = 32'h0;
        rs1Data   = 32'h0;
        rs2Data   = 32'h0;
        resReady  = 1'b1;
        #3;
        check("rst_resValid", {31'b0, resValid}, 32'd0);
        check("rst_opA", opA, 32'd0);
        check("rst_opB", opB, 32'd0);
        check("rst_sel", {28'b0, aluOutSel}, 32'd0);
        check("rst_resData", resData, 32'd0);
        check("rst_resRd", {27'b0, resRd}, 32'd0);
        check("rst_resIllegal", {31'b0, resIllegal}, 32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        #1;
        check("rst_instReady", {31'b0, instReady}, 32'd1);

        // add x3,x1,x2
        send(32'h002081B3, 32'd5, 32'd7);
        check("add_sel", {28'b0, aluOutSel}, 32'd0);
        check("add_opA", opA, 32'd5);
        check("add_opB", opB, 32'd7);
        @(posedge clk);
        #1;
        check("add_resValid", {31'b0, resValid}, 32'd1);
        check("add_resData", resData, 32'd12);
        check("add_resRd", {27'b0, resRd}, 32'd3);

        // sub
        send(32'h402081B3, 32'd5, 32'd7);
        check("sub_sel", {28'b0, aluOutSel}, 32'd1);
        @(posedge clk);
        #1;
        check("sub_resData", resData, 32'hFFFFFFFE);

        // srai x5,x6,4
        send(32'h40435293, 32'hFFFFFF00, 32'h12345678);
        check("srai_opB", opB, 32'd4);
        check("srai_sel", {28'b0, aluOutSel}, 32'd9);
        @(posedge clk);
        #1;
        check("srai_resData", resData, 32'hFFFFFFF0);
        check("srai_resRd", {27'b0, resRd}, 32'd5);

        // sll x4,x1,x2 with junk above the shift amount
        send(32'h00209233, 32'h00000003, 32'h00000124);
        check("sll_opB", opB, 32'd4);
        check("sll_sel", {28'b0, aluOutSel}, 32'd7);
        drain();

        // Back-to-back under a stalled consumer.
        @(negedge clk);
        resReady = 1'b0;
        send(32'h00308133, 32'd10, 32'd20);
        send(32'h40308133, 32'd100, 32'd1);
        @(negedge clk);
        instValid = 1'b1;
        inst      = 32'h0030E133;
        rs1Data   = 32'hF0F0F0F0;
        rs2Data   = 32'h0F0F0000;
        #1;
        check("stall_instReady", {31'b0, instReady}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("stall_s1_opA", opA, 32'd100);
        check("stall_s1_sel", {28'b0, aluOutSel}, 32'd1);
        check("stall_instReady2", {31'b0, instReady}, 32'd0);
        @(negedge clk);
        resReady = 1'b1;
        #1;
        check("release_instReady", {31'b0, instReady}, 32'd1);
        if (instReady) exp_q.push_back(ref_model(inst, rs1Data, rs2Data));
        @(posedge clk);
        #1;
        instValid = 1'b0;
        drain();

        // Illegal opcode.
        send(32'h0000007F, 32'hCAFE0001, 32'h55555555);
`ifdef ALU_ILLEGAL_TRAP_EN
        check("ill_opA", opA, 32'd0);
`else
        check("ill_opA", opA, 32'hCAFE0001);
`endif
        check("ill_opB", opB, 32'd0);
        check("ill_sel", {28'b0, aluOutSel}, 32'd0);
        drain();

        // Reset while a result is waiting.
        @(negedge clk);
        resReady = 1'b0;
        send(32'h0000007F, 32'h00001234, 32'h0);
        @(posedge clk);
        #1;
        check("pre_rst_resValid", {31'b0, resValid}, 32'd1);
`ifdef ALU_ILLEGAL_TRAP_EN
        check("pre_rst_resIllegal", {31'b0, resIllegal}, 32'd1);
        check("pre_rst_resData", resData, 32'd0);
`else
        check("pre_rst_resIllegal", {31'b0, resIllegal}, 32'd0);
        check("pre_rst_resData", resData, 32'h00001234);
`endif
        #2;
        rstN = 1'b0;
        #1;
        check("mid_rst_resValid", {31'b0, resValid}, 32'd0);
        check("mid_rst_resData", resData, 32'd0);
        check("mid_rst_instReady", {31'b0, instReady}, 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstN     = 1'b1;
        resReady = 1'b1;
        #1;
        check("post_rst_resValid", {31'b0, resValid}, 32'd0);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            resReady  = ($urandom_range(0, 9) < 7);
            instValid = ($urandom_range(0, 9) < 7);
            inst      = rand_inst();
            rs1Data   = $urandom;
            rs2Data   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            #1;
            if (instValid && instReady) exp_q.push_back(ref_model(inst, rs1Data, rs2Data));
        end
        @(negedge clk);
        instValid = 1'b0;
        resReady  = 1'b1;
        drain();
        @(negedge clk);
        #1;
        check("final_resValid", {31'b0, resValid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
